instr_mem_ctrl: RTL and testbench

- Parametrised instruction memory with a serial program-loader port and a registered, stallable fetch port.
- It is the next generation of the fixed 256x17 combinational ROM.
- Adds post-reset hardware clear, run-time program loading, one-cycle fetch latency with valid/stall, and an out-of-range guard.
- Sits between the program loader (testbench or UART boot path) and the processor fetch stage.

---
 rtl/instr_mem_pkg.sv | 26 ++
 rtl/instr_mem_ctrl_if.sv | 51 +++++
 rtl/instr_mem_array.sv | 44 ++++
 rtl/instr_mem_ctrl.sv | 161 ++++++++++++++++
 tb/tb_instr_mem_ctrl.sv | 327 ++++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/instr_mem_pkg.sv
// -----------------------------------------------------------------------------
// instr_mem_pkg
// Shared definitions for the instruction memory controller:
//   - default geometry constants (word width, address width, depth)
//   - controller state encoding (CLEAR / RUN / LOAD)
//   - even-parity helper used when INSTR_MEM_PARITY_EN is defined
// -----------------------------------------------------------------------------
package instr_mem_pkg;

    localparam int DEF_IW    = 17;
    localparam int DEF_AW    = 8;
    localparam int DEF_DEPTH = 256;

    typedef enum logic [1:0] {
        CLEAR = 2'd0,
        RUN   = 2'd1,
        LOAD  = 2'd2
    } state_e;

    // Even parity over a zero-extended word: the stored bit makes the total
    // number of ones even. Zero-extension does not change the result.
    function automatic logic even_parity(input logic [63:0] word);
        return ^word;
    endfunction

endpackage

// File: rtl/instr_mem_ctrl_if.sv
// -----------------------------------------------------------------------------
// instr_mem_ctrl_if
// Bundles the program-loader and fetch signals of instr_mem_ctrl.
//   master : loader / fetch stage side (drives load_* and fetch_*)
//   slave  : memory controller side (drives load_ready, load_done, instr,
//            instr_valid, busy and, with INSTR_MEM_PARITY_EN, parity_err)
// Parameters: IW instruction width, AW address width.
// -----------------------------------------------------------------------------
interface instr_mem_ctrl_if
    import instr_mem_pkg::*;
#(
    parameter int IW = DEF_IW,
    parameter int AW = DEF_AW
);
    // program loader
    logic          load_start;
    logic          load_valid;
    logic          load_last;
    logic [IW-1:0] load_data;
    logic          load_ready;
    logic          load_done;
    // fetch port
    logic          fetch_req;
    logic [AW-1:0] fetch_addr;
    logic          fetch_stall;
    logic [IW-1:0] instr;
    logic          instr_valid;
    logic          busy;
`ifdef INSTR_MEM_PARITY_EN
    logic          parity_err;
`endif

    modport master (
        output load_start, load_valid, load_last, load_data,
        output fetch_req, fetch_addr, fetch_stall,
        input  load_ready, load_done, instr, instr_valid, busy
`ifdef INSTR_MEM_PARITY_EN
        , input parity_err
`endif
    );

    modport slave (
        input  load_start, load_valid, load_last, load_data,
        input  fetch_req, fetch_addr, fetch_stall,
        output load_ready, load_done, instr, instr_valid, busy
`ifdef INSTR_MEM_PARITY_EN
        , output parity_err
`endif
    );

endinterface

// File: rtl/instr_mem_array.sv
// -----------------------------------------------------------------------------
// instr_mem_array
// DEPTH x WW synchronous RAM: one write port, one registered read port.
//   clk, rst : clock, asynchronous active-high reset (read register only)
//   we, waddr, wdata : write port, written on the rising edge
//   re, raddr        : read enable / address; rdata updates on the next edge
//   rdata            : registered read data, holds while re is low
// -----------------------------------------------------------------------------
module instr_mem_array
    import instr_mem_pkg::*;
#(
    parameter int WW    = DEF_IW,
    parameter int AW    = DEF_AW,
    parameter int DEPTH = DEF_DEPTH
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          we,
    input  logic [AW-1:0] waddr,
    input  logic [WW-1:0] wdata,
    input  logic          re,
    input  logic [AW-1:0] raddr,
    output logic [WW-1:0] rdata
);

    logic [WW-1:0] mem [DEPTH];

    // NOTE: the storage array has no reset; the controller's CLEAR state
    // zeroes it after reset, which keeps this mappable onto a plain RAM macro.
    always_ff @(posedge clk) begin
        if (we) begin
            mem[waddr] <= wdata;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rdata <= '0;
        end else if (re) begin
            rdata <= mem[raddr];
        end
    end

endmodule

// File: rtl/instr_mem_ctrl.sv
// -----------------------------------------------------------------------------
// instr_mem_ctrl
// Instruction memory with post-reset clear, serial program loader and a
// registered, stallable fetch port.
//   clk, rst      : clock, asynchronous active-high reset
//   bus (slave)   : load_start/valid/last/data -> load_ready, load_done
//                   fetch_req/addr/stall       -> instr, instr_valid
//                   busy (high in CLEAR or LOAD)
//                   parity_err (only with INSTR_MEM_PARITY_EN)
// Optional feature macro: INSTR_MEM_PARITY_EN adds an even-parity bit per
// stored word and a parity_err flag registered alongside instr.
// -----------------------------------------------------------------------------
module instr_mem_ctrl
    import instr_mem_pkg::*;
#(
    parameter int            IW       = DEF_IW,
    parameter int            AW       = DEF_AW,
    parameter int            DEPTH    = DEF_DEPTH,
    parameter logic [IW-1:0] NOP_WORD = '0
) (
    input  logic             clk,
    input  logic             rst,
    instr_mem_ctrl_if.slave  bus
);

`ifdef INSTR_MEM_PARITY_EN
    localparam int WW = IW + 1;
`else
    localparam int WW = IW;
`endif

    localparam logic [AW-1:0] LAST_PTR = AW'(DEPTH - 1);

    state_e        state_q, state_d;
    logic [AW-1:0] ptr_q, ptr_d;
    logic          load_done_q, load_done_d;
    logic          valid_q, valid_d;
    logic          oor_q, oor_d;

    logic          we;
    logic [WW-1:0] wdata;
    logic          re;
    logic [WW-1:0] rdata;
    logic          at_end;
    logic          fetch_go;
    logic          addr_oor;

    assign at_end   = (ptr_q == LAST_PTR);
    assign addr_oor = (32'(bus.fetch_addr) >= 32'(DEPTH));
    // A fetch is only taken in RUN, and a same-cycle load request wins.
    assign fetch_go = (state_q == RUN) && bus.fetch_req && !bus.load_start;

    // NOTE: state registers use non-blocking assignments so every flop samples
    // the pre-edge values computed by the combinational block.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= CLEAR;
            ptr_q       <= '0;
            load_done_q <= 1'b0;
            valid_q     <= 1'b0;
            oor_q       <= 1'b0;
        end else begin
            state_q     <= state_d;
            ptr_q       <= ptr_d;
            load_done_q <= load_done_d;
            valid_q     <= valid_d;
            oor_q       <= oor_d;
        end
    end

    // NOTE: every signal written here gets a default first, so no path can
    // leave it unassigned and infer a latch.
    always_comb begin
        state_d     = state_q;
        ptr_d       = ptr_q;
        load_done_d = 1'b0;
        we          = 1'b0;
        wdata       = '0;
        re          = 1'b0;
        valid_d     = valid_q;
        oor_d       = oor_q;

        unique case (state_q)
            CLEAR: begin
                // zero one word per cycle; ptr stops at the last word
                we = 1'b1;
                if (at_end) begin
                    state_d = RUN;
                end else begin
                    ptr_d = ptr_q + AW'(1);
                end
            end
            RUN: begin
                if (bus.load_start) begin
                    state_d = LOAD;
                    ptr_d   = '0;
                end
            end
            LOAD: begin
                // load_ready is high for the whole LOAD state
                if (bus.load_valid) begin
                    we = 1'b1;
`ifdef INSTR_MEM_PARITY_EN
                    wdata = {even_parity(64'(bus.load_data)), bus.load_data};
`else
                    wdata = bus.load_data;
`endif
                    if (bus.load_last || at_end) begin
                        state_d     = RUN;
                        load_done_d = 1'b1;
                    end else begin
                        ptr_d = ptr_q + AW'(1);
                    end
                end
            end
            default: begin
                state_d = CLEAR;
                ptr_d   = '0;
            end
        endcase

        // Fetch side: a stall freezes instr/instr_valid (and the read register).
        if (!bus.fetch_stall) begin
            valid_d = fetch_go;
            if (fetch_go) begin
                oor_d = addr_oor;
                re    = !addr_oor;
            end
        end
    end

    instr_mem_array #(
        .WW    (WW),
        .AW    (AW),
        .DEPTH (DEPTH)
    ) u_array (
        .clk   (clk),
        .rst   (rst),
        .we    (we),
        .waddr (ptr_q),
        .wdata (wdata),
        .re    (re),
        .raddr (bus.fetch_addr),
        .rdata (rdata)
    );

    assign bus.load_ready  = (state_q == LOAD);
    assign bus.load_done   = load_done_q;
    assign bus.busy        = (state_q != RUN);
    assign bus.instr_valid = valid_q;
    // Out-of-range fetches leave the read register untouched and substitute
    // NOP_WORD on the way out.
    assign bus.instr       = oor_q ? NOP_WORD : rdata[IW-1:0];

`ifdef INSTR_MEM_PARITY_EN
    // Recomputed over the registered word including its stored parity bit;
    // tracks instr because both come from the same read register.
    assign bus.parity_err  = !oor_q && (^rdata);
`endif

endmodule

// File: tb/tb_instr_mem_ctrl.sv
// -----------------------------------------------------------------------------
// tb_instr_mem_ctrl
// Self-checking bench for instr_mem_ctrl. Two instances: dut (DEPTH=256,
// NOP_WORD=0) and dut2 (DEPTH=200, NOP_WORD=17'h1C000). A word-array model
// of dut's contents and a simple fetch-output model provide expected values.
// -----------------------------------------------------------------------------
module tb_instr_mem_ctrl;

    localparam int IW = 17;
    localparam int AW = 8;
    localparam int D1 = 256;
    localparam int D2 = 200;
    localparam logic [IW-1:0] NOP2 = 17'h1C000;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    instr_mem_ctrl_if #(.IW(IW), .AW(AW)) bus1 ();
    instr_mem_ctrl_if #(.IW(IW), .AW(AW)) bus2 ();

    instr_mem_ctrl #(.IW(IW), .AW(AW), .DEPTH(D1), .NOP_WORD(17'h0)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus1.slave)
    );

    instr_mem_ctrl #(.IW(IW), .AW(AW), .DEPTH(D2), .NOP_WORD(NOP2)) dut2 (
        .clk (clk),
        .rst (rst),
        .bus (bus2.slave)
    );

    int total = 0;
    int bad   = 0;

    logic [IW-1:0] model1 [D1];     // expected contents of dut
    logic [IW-1:0] beat_data [300]; // data driven on load beats
    logic [IW-1:0] m_instr;         // expected dut instr
    logic          m_valid;         // expected dut instr_valid

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(negedge clk);
    endtask

    task automatic model_clear();
        for (int i = 0; i < D1; i++) model1[i] = '0;
    endtask

    // Counts cycles from reset release until busy falls on both instances.
    task automatic wait_clear(input string tag);
        int lo1 = -1;
        int lo2 = -1;
        logic any_done = 1'b0;
        for (int n = 0; n < 400; n++) begin
            if (!bus1.busy && lo1 < 0) lo1 = n;
            if (!bus2.busy && lo2 < 0) lo2 = n;
            any_done = any_done | bus1.load_done;
            if (lo1 >= 0 && lo2 >= 0) break;
            tick();
        end
        check({tag, "_busy_cycles_d256"}, lo1, D1);
        check({tag, "_busy_cycles_d200"}, lo2, D2);
        check({tag, "_no_done_in_clear"}, any_done, 1'b0);
    endtask

    // Single fetch on dut, no stall; checks the word one cycle later.
    task automatic fetch1(input logic [AW-1:0] a, input string tag);
        bus1.fetch_req  = 1'b1;
        bus1.fetch_addr = a;
        tick();
        bus1.fetch_req  = 1'b0;
        m_instr = model1[a];
        m_valid = 1'b1;
        check({tag, "_instr"}, bus1.instr, model1[a]);
        check({tag, "_valid"}, bus1.instr_valid, 1'b1);
`ifdef INSTR_MEM_PARITY_EN
        check({tag, "_perr"}, bus1.parity_err, 1'b0);
`endif
    endtask

    // Program load of n beats from beat_data; load_last on the final beat if
    // use_last. Acceptance stops after DEPTH words.
    task automatic do_load(input int n, input logic use_last, input string tag);
        int   accepted = 0;
        logic ended    = 1'b0;
        logic exp_done;
        int   dones    = 0;
        bus1.load_start = 1'b1;
        tick();
        bus1.load_start = 1'b0;
        check({tag, "_ready_rise"}, bus1.load_ready, 1'b1);
        check({tag, "_busy_in_load"}, bus1.busy, 1'b1);
        for (int i = 0; i < n; i++) begin
            if ($urandom_range(0, 3) == 0) begin
                bus1.load_valid = 1'b0;
                tick();
                check({tag, "_gap_done"}, bus1.load_done, 1'b0);
                dones += int'(bus1.load_done);
            end
            check({tag, "_ready"}, bus1.load_ready, !ended);
            bus1.load_valid = 1'b1;
            bus1.load_data  = beat_data[i];
            bus1.load_last  = use_last && (i == n - 1);
            tick();
            exp_done = 1'b0;
            if (!ended) begin
                model1[accepted] = beat_data[i];
                accepted++;
                if (bus1.load_last || accepted == D1) begin
                    ended    = 1'b1;
                    exp_done = 1'b1;
                end
            end
            check({tag, "_done"}, bus1.load_done, exp_done);
            dones += int'(bus1.load_done);
            if (exp_done) check({tag, "_busy_fall"}, bus1.busy, 1'b0);
        end
        bus1.load_valid = 1'b0;
        bus1.load_last  = 1'b0;
        tick();
        check({tag, "_done_after"}, bus1.load_done, 1'b0);
        dones += int'(bus1.load_done);
        check({tag, "_done_count"}, dones, 1);
        m_valid = 1'b0;
    endtask

    // Random fetch/stall traffic on dut while in RUN.
    task automatic rand_fetch(input int n);
        logic          req;
        logic          stall;
        logic [AW-1:0] a;
        for (int i = 0; i < n; i++) begin
            req   = 1'($urandom_range(0, 1));
            stall = ($urandom_range(0, 3) == 0);
            a     = AW'($urandom);
            bus1.fetch_req   = req;
            bus1.fetch_stall = stall;
            bus1.fetch_addr  = a;
            if (!stall) begin
                if (req) begin
                    m_instr = model1[a];
                    m_valid = 1'b1;
                end else begin
                    m_valid = 1'b0;
                end
            end
            tick();
            check("rand_instr", bus1.instr, m_instr);
            check("rand_valid", bus1.instr_valid, m_valid);
        end
        bus1.fetch_req   = 1'b0;
        bus1.fetch_stall = 1'b0;
    endtask

    initial begin
        logic [IW-1:0] w;
        rst = 1'b1;
        bus1.load_start = 0; bus1.load_valid = 0; bus1.load_last = 0; bus1.load_data = '0;
        bus1.fetch_req  = 0; bus1.fetch_addr = '0; bus1.fetch_stall = 0;
        bus2.load_start = 0; bus2.load_valid = 0; bus2.load_last = 0; bus2.load_data = '0;
        bus2.fetch_req  = 0; bus2.fetch_addr = '0; bus2.fetch_stall = 0;
        m_instr = '0;
        m_valid = 1'b0;
        model_clear();
        tick();
        tick();

        // reset values
        check("rst_instr", bus1.instr, 17'h0);
        check("rst_valid", bus1.instr_valid, 1'b0);
        check("rst_ready", bus1.load_ready, 1'b0);
        check("rst_done", bus1.load_done, 1'b0);
        check("rst_busy", bus1.busy, 1'b1);
`ifdef INSTR_MEM_PARITY_EN
        check("rst_perr", bus1.parity_err, 1'b0);
`endif
        rst = 1'b0;
        wait_clear("clear1");

        // cleared contents
        fetch1(8'h00, "clr_a00");
        fetch1(8'h7F, "clr_a7f");
        fetch1(8'hFF, "clr_aff");
        tick();
        check("noreq_valid", bus1.instr_valid, 1'b0);
        check("noreq_hold", bus1.instr, 17'h0);

        // directed four-beat load
        beat_data[0] = 17'h1A5A5;
        beat_data[1] = 17'h00001;
        beat_data[2] = 17'h1FFFF;
        beat_data[3] = 17'h0F0F0;
        do_load(4, 1'b1, "load4");
        fetch1(8'd3, "load4_a3");
        check("load4_a3_const", bus1.instr, 17'h0F0F0);
        fetch1(8'd0, "load4_a0");

        // stall: addr 1 result held while stalled, addr 2 appears afterwards
        bus1.fetch_req  = 1'b1;
        bus1.fetch_addr = 8'd1;
        tick();
        check("stall_first", bus1.instr, 17'h00001);
        bus1.fetch_addr  = 8'd2;
        bus1.fetch_stall = 1'b1;
        for (int i = 0; i < 3; i++) begin
            tick();
            check("stall_hold_instr", bus1.instr, 17'h00001);
            check("stall_hold_valid", bus1.instr_valid, 1'b1);
        end
        bus1.fetch_stall = 1'b0;
        tick();
        check("stall_release_instr", bus1.instr, 17'h1FFFF);
        check("stall_release_valid", bus1.instr_valid, 1'b1);
        bus1.fetch_req = 1'b0;
        tick();
        check("stall_after_valid", bus1.instr_valid, 1'b0);
        check("stall_after_hold", bus1.instr, 17'h1FFFF);

        // random loads followed by random fetch traffic
        for (int k = 0; k < 3; k++) begin
            int n = $urandom_range(1, 40);
            for (int i = 0; i < n; i++) beat_data[i] = IW'($urandom);
            do_load(n, 1'b1, "rload");
            fetch1(8'd0, "rload_a0");
            rand_fetch(60);
        end

        // overlong load without load_last: stops at DEPTH words
        for (int i = 0; i < 300; i++) beat_data[i] = IW'($urandom);
        do_load(300, 1'b0, "load300");
        fetch1(8'hFF, "load300_aff");
        check("load300_aff_beat256", bus1.instr, beat_data[255]);
        fetch1(8'h00, "load300_a00");
        check("load300_a00_beat1", bus1.instr, beat_data[0]);
        rand_fetch(40);

        // out-of-range fetch on the 200-deep instance
        bus2.fetch_req  = 1'b1;
        bus2.fetch_addr = 8'd250;
        tick();
        check("oor_instr", bus2.instr, NOP2);
        check("oor_valid", bus2.instr_valid, 1'b1);
        bus2.fetch_addr = 8'd199;
        tick();
        check("inrange_last_instr", bus2.instr, 17'h0);
        check("inrange_last_valid", bus2.instr_valid, 1'b1);
        bus2.fetch_addr = 8'd200;
        tick();
        check("oor_first_instr", bus2.instr, NOP2);
        bus2.fetch_req = 1'b0;
        tick();
        check("oor_noreq_valid", bus2.instr_valid, 1'b0);
        check("oor_noreq_hold", bus2.instr, NOP2);

        // load_start and fetch_req together: load wins
        bus1.load_start = 1'b1;
        bus1.fetch_req  = 1'b1;
        bus1.fetch_addr = 8'd3;
        tick();
        bus1.load_start = 1'b0;
        bus1.fetch_req  = 1'b0;
        check("collide_valid", bus1.instr_valid, 1'b0);
        check("collide_busy", bus1.busy, 1'b1);
        bus1.fetch_req = 1'b1;
        tick();
        bus1.fetch_req = 1'b0;
        check("busy_fetch_valid", bus1.instr_valid, 1'b0);
        w = IW'($urandom);
        bus1.load_valid = 1'b1;
        bus1.load_last  = 1'b1;
        bus1.load_data  = w;
        tick();
        bus1.load_valid = 1'b0;
        bus1.load_last  = 1'b0;
        model1[0] = w;
        check("collide_done", bus1.load_done, 1'b1);
        fetch1(8'd0, "collide_a0");

`ifdef INSTR_MEM_PARITY_EN
        // corrupt the stored parity of word 5
        dut.u_array.mem[5][IW] = ~dut.u_array.mem[5][IW];
        bus1.fetch_req  = 1'b1;
        bus1.fetch_addr = 8'd5;
        tick();
        check("perr_set", bus1.parity_err, 1'b1);
        check("perr_instr", bus1.instr, model1[5]);
        bus1.fetch_req = 1'b0;
        fetch1(8'd6, "perr_clear");
`endif

        // reset in the middle of a five-beat load, after two beats
        bus1.load_start = 1'b1;
        tick();
        bus1.load_start = 1'b0;
        for (int i = 0; i < 2; i++) begin
            bus1.load_valid = 1'b1;
            bus1.load_data  = IW'($urandom) | 17'h1;
            tick();
        end
        bus1.load_valid = 1'b0;
        rst = 1'b1;
        #1;
        check("midrst_done", bus1.load_done, 1'b0);
        check("midrst_busy", bus1.busy, 1'b1);
        check("midrst_ready", bus1.load_ready, 1'b0);
        check("midrst_valid", bus1.instr_valid, 1'b0);
        tick();
        rst = 1'b0;
        model_clear();
        wait_clear("clear2");
        fetch1(8'd0, "midrst_a0");
        fetch1(8'd1, "midrst_a1");

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
